// File: rtl/reg_mem_cmd_pkg.sv
// reg_mem_cmd_pkg: shared opcodes, FSM state encoding and sizing helper for the command bridge
package reg_mem_cmd_pkg;
    localparam logic [7:0] OPC_WRITE = 8'h57;
    localparam logic [7:0] OPC_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h41;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, ACK, RCAP, TX} state_t;
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/reg_mem_cmd_timer.sv
// reg_mem_cmd_timer: inter-byte idle counter that pulses expire on the TIMEOUT_CYCLES-th idle cycle
module reg_mem_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;
    assign o_expire = (TIMEOUT_CYCLES != 0) & i_en & (r_cnt == LAST);
    // count idle cycles; restart on clear or after firing
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= (i_clear | o_expire) ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
    end
endmodule

// File: rtl/reg_mem_cmd_bridge.sv
// reg_mem_cmd_bridge: parses W/R byte commands from the UART side and drives the register memory
module reg_mem_cmd_bridge
    import reg_mem_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  err
);
    localparam int ABYTES = (ADDR_WIDTH + 7) / 8;
    localparam int DBYTES = DATA_WIDTH / 8;
    localparam int CW = cnt_width((ABYTES > DBYTES) ? ABYTES : DBYTES);
    localparam logic [CW-1:0] A_LAST = CW'(ABYTES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DBYTES - 1);
    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_is_read, r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_shift;
    logic                  w_rx, w_tx, w_rx_phase, w_opc_ok, w_expire;
    assign w_rx       = rx_valid & rx_ready;
    assign w_tx       = tx_valid & tx_ready;
    assign w_rx_phase = (r_state == ADDR) | (r_state == WDATA);
    assign w_opc_ok   = (rx_data == OPC_WRITE) | (rx_data == OPC_READ);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign err        = r_err;
    reg_mem_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_rx_phase | w_rx),
        .i_en     (w_rx_phase & !w_rx),
        .o_expire (w_expire)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    // next-state decode; a timeout abandons the partial command
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_rx & w_opc_ok) ? ADDR : IDLE;
            ADDR:    w_next = w_expire ? IDLE : (w_rx & (r_cnt == A_LAST)) ? (r_is_read ? RCAP : WDATA) : ADDR;
            WDATA:   w_next = w_expire ? IDLE : (w_rx & (r_cnt == D_LAST)) ? WRITE : WDATA;
            WRITE:   w_next = ACK;
            ACK:     w_next = tx_ready ? IDLE : ACK;
            RCAP:    w_next = TX;
            TX:      w_next = (w_tx & (r_cnt == D_LAST)) ? IDLE : TX;
            default: w_next = IDLE;
        endcase
    end
    // handshake and strobe outputs decoded from state; tx side holds until accepted
    always_comb begin
        rx_ready = (r_state == IDLE) | w_rx_phase;
        tx_valid = (r_state == ACK) | (r_state == TX);
        tx_data  = (r_state == ACK) ? RSP_ACK : (r_state == TX) ? r_shift[DATA_WIDTH-1 -: 8] : 8'h00;
        mem_we   = r_state == WRITE;
        busy     = r_state != IDLE;
    end
    // byte counter, address/data/response shift registers and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_is_read <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_shift   <= '0;
        end else begin
            r_err <= ((r_state == IDLE) & w_rx & !w_opc_ok) | w_expire;
            r_cnt <= (w_next != r_state) ? '0 :
                     ((w_rx & w_rx_phase) | (w_tx & (r_state == TX))) ? r_cnt + 1'b1 : r_cnt;
            if ((r_state == IDLE) && w_rx)
                r_is_read <= rx_data == OPC_READ;
            if ((r_state == ADDR) && w_rx)
                r_addr <= ADDR_WIDTH'({r_addr, rx_data});
            if ((r_state == WDATA) && w_rx)
                r_wdata <= DATA_WIDTH'({r_wdata, rx_data});
            if (r_state == RCAP)
                r_shift <= mem_rdata;
            else if ((r_state == TX) && w_tx)
                r_shift <= r_shift << 8;
        end
    end
endmodule
